pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
Datapath-side consumer of the branch control-unit outputs. It holds the program counter, the {V,C,N,Z} status register and the control-unit state register. It executes the PC_FS function encoded in the control word: hold, +4, load from register, or PC-relative jump. It feeds PC, status and state back to the control units and also keeps a taken-branch counter and a sticky misalignment flag.

Parameters:
PC_WIDTH, 64, width of PC, reg_in and the target arithmetic
RESET_PC, 0, PC value after reset
CNT_WIDTH, 16, width of the saturating taken-branch counter

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
PC_FS  in  2  PC function: 00 hold, 01 PC+4, 10 load reg_in, 11 PC-relative jump
status_load  in  1  load alu_status into the status register
alu_status  in  4  {V,C,N,Z} from the ALU this cycle
NS  in  4  next state from the control unit
IR  in  32  current instruction; source of the jump offset
reg_in  in  PC_WIDTH  register-file value for the register-branch (BR) load
PC  out  PC_WIDTH  current program counter (registered)
PC_plus4  out  PC_WIDTH  PC+4, combinational; used as the link value
status  out  4  registered {V,C,N,Z}
state  out  4  registered control-unit state
misalign  out  1  sticky; set when reg_in[1:0]!=0 on a PC_FS=10 load
branch_count  out  CNT_WIDTH  taken-branch count, saturating

Behaviour:
- Reset (reset_n low, asynchronous): PC=RESET_PC, status=0000, state=0000, misalign=0, branch_count=0. Reset has priority over every other input. Asserting reset mid-instruction drops the in-flight operation; the first edge after release performs a normal update.
- state <= NS on every clock edge, with a latency of 1 cycle. No other logic modifies state.
- status <= alu_status when status_load=1; otherwise it holds. The new value is visible on the next cycle, so a CB instruction loads flags in EX0 and they are tested in EX1.
- PC update, one per edge:
  - 00: PC holds.
  - 01: PC <= PC+4.
  - 10: PC <= {reg_in[PC_WIDTH-1:2],2'b00}. If reg_in[1:0]!=0, misalign is set to 1 and stays 1 until reset.
  - 11: PC <= PC + (sext(imm)<<2), where imm is selected by IR[31:29]:
    - 000 (B) or 100 (BL): imm = IR[25:0], 26-bit.
    - 101 (CB) or 010 (bcond): imm = IR[23:5], 19-bit.
    - Any other value: offset is 0, so PC holds. This case is not counted as taken.
- All adds are modulo 2^PC_WIDTH. Wrap-around is allowed and is not flagged.
- PC_plus4 = PC+4 combinationally, also modulo.
- branch_count increments by 1 on any edge where PC_FS=10, or PC_FS=11 with a valid opcode. It saturates at all-ones and never wraps.
- Simultaneous events: status_load, the PC update and the state update are independent and all occur on the same edge. A status load never changes the PC in the same cycle.

Test Plan:
- Reset/increment: release reset with RESET_PC=0, drive PC_FS=01 for 3 cycles -> PC goes 4, 8, 12; PC_plus4=16; branch_count=0.
- B jump: PC=0x100, IR=0x17FFFFFE (B, imm26=-2), PC_FS=11 -> PC=0xF8, branch_count=1.
- CB flags: cycle0 status_load=1, alu_status=0001, NS=0010, PC_FS=00; cycle1 IR=0xB4000040 (CB, imm19=2), PC_FS=11 -> status=0001 and state=0010 after cycle0; PC=PC+8 after cycle1.
- BR misaligned: reg_in=0x2003, PC_FS=10 -> PC=0x2000, misalign=1; a later aligned BR leaves misalign=1.
- Wrap/saturate: PC=0xFFFF_FFFF_FFFF_FFFC, PC_FS=01 -> PC=0. Preload branch_count to 0xFFFF via 65535 jumps, one more jump -> stays 0xFFFF.
- Async reset mid-jump: assert reset_n low between edges while PC_FS=11 -> outputs reset immediately without waiting for a clock edge; no jump applied.

Source files
------------

// File: rtl/pc_branch_unit.sv
// pc_branch_unit
// Datapath side of the branch control unit. It holds the program counter,
// the {V,C,N,Z} status flags and the control-unit state register. It applies
// the PC function from the control word (hold, +4, register load, or a
// PC-relative jump). It also keeps a saturating taken-branch counter and a
// sticky flag for misaligned register-branch targets.
module pc_branch_unit #(
    parameter int                  PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           PC_FS,
    input  logic                 status_load,
    input  logic [3:0]           alu_status,
    input  logic [3:0]           NS,
    input  logic [31:0]          IR,
    input  logic [PC_WIDTH-1:0]  reg_in,
    output logic [PC_WIDTH-1:0]  PC,
    output logic [PC_WIDTH-1:0]  PC_plus4,
    output logic [3:0]           status,
    output logic [3:0]           state,
    output logic                 misalign,
    output logic [CNT_WIDTH-1:0] branch_count
);

    localparam logic [1:0] FS_HOLD = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_REG  = 2'b10;
    localparam logic [1:0] FS_REL  = 2'b11;

    localparam logic [PC_WIDTH-1:0]  PC_FOUR = PC_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [PC_WIDTH-1:0]  r_pc;
    logic [3:0]           r_status;
    logic [3:0]           r_state;
    logic                 r_misalign;
    logic [CNT_WIDTH-1:0] r_count;

    logic [PC_WIDTH-1:0]  w_pc_plus4;
    logic [PC_WIDTH-1:0]  w_offset;
    logic                 w_rel_valid;
    logic [PC_WIDTH-1:0]  w_pc_next;
    logic                 w_taken;
    logic                 w_reg_misaligned;
    logic                 w_unused_ir;

    // Only the opcode field and the two immediate fields of IR matter here.
    assign w_unused_ir = ^{IR[28:26], IR[4:0]};

    assign w_pc_plus4       = r_pc + PC_FOUR;
    assign w_reg_misaligned = (reg_in[1:0] != 2'b00);

    // Decode the jump offset (already scaled to bytes) from the opcode field.
    // Unrecognised opcodes give a zero offset and do not count as taken.
    always_comb begin
        w_offset    = '0;
        w_rel_valid = 1'b0;
        case (IR[31:29])
            3'b000, 3'b100: begin
                w_offset    = {{(PC_WIDTH-28){IR[25]}}, IR[25:0], 2'b00};
                w_rel_valid = 1'b1;
            end
            3'b101, 3'b010: begin
                w_offset    = {{(PC_WIDTH-21){IR[23]}}, IR[23:5], 2'b00};
                w_rel_valid = 1'b1;
            end
            default: begin
                w_offset    = '0;
                w_rel_valid = 1'b0;
            end
        endcase
    end

    // Select the next PC and decide whether this edge is a taken branch.
    always_comb begin
        w_pc_next = r_pc;
        w_taken   = 1'b0;
        case (PC_FS)
            FS_HOLD: w_pc_next = r_pc;
            FS_INC:  w_pc_next = w_pc_plus4;
            FS_REG: begin
                w_pc_next = {reg_in[PC_WIDTH-1:2], 2'b00};
                w_taken   = 1'b1;
            end
            FS_REL: begin
                w_pc_next = r_pc + w_offset;
                w_taken   = w_rel_valid;
            end
            default: w_pc_next = r_pc;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Status flags load from the ALU only when asked; otherwise they hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_status <= 4'b0000;
        end else if (status_load) begin
            r_status <= alu_status;
        end
    end

    // Control-unit state simply follows NS with one cycle of latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= 4'b0000;
        end else begin
            r_state <= NS;
        end
    end

    // Sticky misalignment flag; only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_misalign <= 1'b0;
        end else if ((PC_FS == FS_REG) && w_reg_misaligned) begin
            r_misalign <= 1'b1;
        end
    end

    // Taken-branch counter, saturating at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_taken && (r_count != '1)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign PC           = r_pc;
    assign PC_plus4     = w_pc_plus4;
    assign status       = r_status;
    assign state        = r_state;
    assign misalign     = r_misalign;
    assign branch_count = r_count;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Testbench for pc_branch_unit: a reference model pushes the expected
// register state for every driven cycle; each test pops and compares.
module tb_pc_branch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  PC_FS = 2'b00;
    logic        status_load = 1'b0;
    logic [3:0]  alu_status = 4'h0;
    logic [3:0]  NS = 4'h0;
    logic [31:0] IR = 32'h0;
    logic [63:0] reg_in = 64'h0;
    logic [63:0] PC;
    logic [63:0] PC_plus4;
    logic [3:0]  status;
    logic [3:0]  state;
    logic        misalign;
    logic [15:0] branch_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  st;
        logic [3:0]  sa;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [63:0] m_pc;
    logic [3:0]  m_st;
    logic [3:0]  m_sa;
    logic        m_mis;
    logic [15:0] m_cnt;

    pc_branch_unit #(
        .PC_WIDTH (64),
        .RESET_PC (64'h0),
        .CNT_WIDTH(16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .PC_FS       (PC_FS),
        .status_load (status_load),
        .alu_status  (alu_status),
        .NS          (NS),
        .IR          (IR),
        .reg_in      (reg_in),
        .PC          (PC),
        .PC_plus4    (PC_plus4),
        .status      (status),
        .state       (state),
        .misalign    (misalign),
        .branch_count(branch_count)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pc  = 64'h0;
        m_st  = 4'h0;
        m_sa  = 4'h0;
        m_mis = 1'b0;
        m_cnt = 16'h0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, push the model's expectation, and wait
    // until just after the edge that consumes it.
    task automatic drive_cycle(input logic [1:0] fs, input logic sl, input logic [3:0] as,
                               input logic [3:0] ns, input logic [31:0] ir, input logic [63:0] rin);
        logic        taken;
        logic [63:0] off;
        exp_t        e;
        PC_FS = fs; status_load = sl; alu_status = as; NS = ns; IR = ir; reg_in = rin;
        taken = 1'b0;
        off   = 64'h0;
        if (fs == 2'b01) begin
            m_pc = m_pc + 64'd4;
        end else if (fs == 2'b10) begin
            if (rin[1:0] != 2'b00) m_mis = 1'b1;
            m_pc  = {rin[63:2], 2'b00};
            taken = 1'b1;
        end else if (fs == 2'b11) begin
            if (ir[31:29] == 3'b000 || ir[31:29] == 3'b100) begin
                off   = {{38{ir[25]}}, ir[25:0]};
                taken = 1'b1;
            end else if (ir[31:29] == 3'b101 || ir[31:29] == 3'b010) begin
                off   = {{45{ir[23]}}, ir[23:5]};
                taken = 1'b1;
            end
            m_pc = m_pc + (off << 2);
        end
        if (taken && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (sl) m_st = as;
        m_sa = ns;
        e.pc = m_pc; e.st = m_st; e.sa = m_sa; e.mis = m_mis; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        #3;
        total++;
        if ({PC, status, state, misalign, branch_count} !== {64'h0, 4'h0, 4'h0, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL reset_state: got pc=%h st=%h sa=%h mis=%b cnt=%h want all zero",
                     PC, status, state, misalign, branch_count);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (PC_plus4 !== 64'h4) begin
            bad++;
            $display("FAIL reset_plus4: got %h want 4", PC_plus4);
        end
        e.pc = 0;
    endtask

    task automatic test_increment();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(2'b01, 1'b0, 4'h0, 4'h0, 32'h0, 64'h0);
            e = sb.pop_front();
            total++;
            if ({PC, status, state, misalign, branch_count} !== {e.pc, e.st, e.sa, e.mis, e.cnt}) begin
                bad++;
                $display("FAIL incr[%0d]: got pc=%h st=%h sa=%h mis=%b cnt=%h want pc=%h st=%h sa=%h mis=%b cnt=%h",
                         i, PC, status, state, misalign, branch_count, e.pc, e.st, e.sa, e.mis, e.cnt);
            end
        end
        total++;
        if (PC !== 64'd12 || PC_plus4 !== 64'd16 || branch_count !== 16'd0) begin
            bad++;
            $display("FAIL incr_final: got pc=%h plus4=%h cnt=%h want pc=c plus4=10 cnt=0",
                     PC, PC_plus4, branch_count);
        end
    endtask

    task automatic test_jumps();
        exp_t        e;
        logic [15:0] c0;
        logic [31:0] irs [4];
        irs[0] = 32'h17FFFFFE;   // B, -2 words
        irs[1] = 32'h80000010;   // BL, +16 words
        irs[2] = 32'h40000060;   // bcond, +3 words
        irs[3] = 32'hE0000010;   // unrecognised opcode: hold, not taken
        drive_cycle(2'b10, 1'b0, 4'h0, 4'h0, 32'h0, 64'h100);
        e = sb.pop_front();
        total++;
        if (PC !== 64'h100 || PC !== e.pc) begin
            bad++;
            $display("FAIL br_to_100: got pc=%h want 100", PC);
        end
        c0 = branch_count;
        drive_cycle(2'b11, 1'b0, 4'h0, 4'h0, irs[0], 64'h0);
        e = sb.pop_front();
        total++;
        if (PC !== 64'hF8 || branch_count !== c0 + 16'd1) begin
            bad++;
            $display("FAIL b_jump: got pc=%h cnt=%h want pc=f8 cnt=%h", PC, branch_count, c0 + 16'd1);
        end
        for (int i = 1; i < 4; i++) begin
            drive_cycle(2'b11, 1'b0, 4'h0, 4'h0, irs[i], 64'h0);
            e = sb.pop_front();
            total++;
            if ({PC, status, state, misalign, branch_count} !== {e.pc, e.st, e.sa, e.mis, e.cnt}) begin
                bad++;
                $display("FAIL jump[%0d]: got pc=%h cnt=%h want pc=%h cnt=%h",
                         i, PC, branch_count, e.pc, e.cnt);
            end
        end
        total++;
        if (PC !== 64'h144 || branch_count !== c0 + 16'd3) begin
            bad++;
            $display("FAIL jump_final: got pc=%h cnt=%h want pc=144 cnt=%h", PC, branch_count, c0 + 16'd3);
        end
    endtask

    task automatic test_cb_flags();
        exp_t        e;
        logic [63:0] p0;
        p0 = PC;
        drive_cycle(2'b00, 1'b1, 4'b0001, 4'b0010, 32'h0, 64'h0);
        e = sb.pop_front();
        total++;
        if (status !== 4'b0001 || state !== 4'b0010 || PC !== p0 || PC !== e.pc) begin
            bad++;
            $display("FAIL cb_ex0: got st=%h sa=%h pc=%h want st=1 sa=2 pc=%h", status, state, PC, p0);
        end
        drive_cycle(2'b11, 1'b0, 4'b1110, 4'b0011, 32'hB4000040, 64'h0);
        e = sb.pop_front();
        total++;
        if (PC !== p0 + 64'd8 || status !== 4'b0001 || state !== 4'b0011 || e.pc !== PC) begin
            bad++;
            $display("FAIL cb_ex1: got pc=%h st=%h sa=%h want pc=%h st=1 sa=3", PC, status, state, p0 + 64'd8);
        end
        drive_cycle(2'b01, 1'b1, 4'b1010, 4'b0101, 32'h0, 64'h0);
        e = sb.pop_front();
        total++;
        if ({PC, status, state, misalign, branch_count} !== {e.pc, e.st, e.sa, e.mis, e.cnt}) begin
            bad++;
            $display("FAIL cb_simul: got pc=%h st=%h sa=%h want pc=%h st=%h sa=%h",
                     PC, status, state, e.pc, e.st, e.sa);
        end
    endtask

    task automatic test_br_misalign();
        exp_t e;
        total++;
        if (misalign !== 1'b0) begin
            bad++;
            $display("FAIL mis_initial: got %b want 0", misalign);
        end
        drive_cycle(2'b10, 1'b0, 4'h0, 4'h0, 32'h0, 64'h2003);
        e = sb.pop_front();
        total++;
        if (PC !== 64'h2000 || misalign !== 1'b1 || e.mis !== misalign) begin
            bad++;
            $display("FAIL br_misaligned: got pc=%h mis=%b want pc=2000 mis=1", PC, misalign);
        end
        drive_cycle(2'b10, 1'b0, 4'h0, 4'h0, 32'h0, 64'h3000);
        e = sb.pop_front();
        total++;
        if (PC !== 64'h3000 || misalign !== 1'b1) begin
            bad++;
            $display("FAIL br_sticky: got pc=%h mis=%b want pc=3000 mis=1", PC, misalign);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        drive_cycle(2'b10, 1'b0, 4'h0, 4'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        e = sb.pop_front();
        total++;
        if (PC !== 64'hFFFF_FFFF_FFFF_FFFC || PC_plus4 !== 64'h0) begin
            bad++;
            $display("FAIL wrap_plus4: got pc=%h plus4=%h want pc=fffffffffffffffc plus4=0", PC, PC_plus4);
        end
        drive_cycle(2'b01, 1'b0, 4'h0, 4'h0, 32'h0, 64'h0);
        e = sb.pop_front();
        total++;
        if (PC !== 64'h0 || PC !== e.pc) begin
            bad++;
            $display("FAIL wrap_inc: got pc=%h want 0", PC);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive_cycle(2'b01, 1'b1, 4'h9, 4'h7, 32'h0, 64'h0);
        e = sb.pop_front();
        drive_cycle(2'b10, 1'b0, 4'h0, 4'h7, 32'h0, 64'h501);
        e = sb.pop_front();
        total++;
        if ({PC, status, state, misalign} !== {e.pc, e.st, e.sa, e.mis}) begin
            bad++;
            $display("FAIL pre_reset: got pc=%h st=%h sa=%h mis=%b want pc=%h st=%h sa=%h mis=%b",
                     PC, status, state, misalign, e.pc, e.st, e.sa, e.mis);
        end
        PC_FS = 2'b11; IR = 32'h00000100; NS = 4'hA; status_load = 1'b1; alu_status = 4'hF;
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({PC, status, state, misalign, branch_count} !== {64'h0, 4'h0, 4'h0, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL async_reset: got pc=%h st=%h sa=%h mis=%b cnt=%h want all zero",
                     PC, status, state, misalign, branch_count);
        end
        model_reset();
        @(posedge clock);
        #1;
        total++;
        if (PC !== 64'h0 || state !== 4'h0) begin
            bad++;
            $display("FAIL reset_priority: got pc=%h sa=%h want 0 0", PC, state);
        end
        @(negedge clock);
        reset_n = 1'b1;
        drive_cycle(2'b01, 1'b0, 4'h0, 4'h3, 32'h0, 64'h0);
        e = sb.pop_front();
        total++;
        if (PC !== 64'h4 || state !== 4'h3 || e.pc !== PC) begin
            bad++;
            $display("FAIL post_reset: got pc=%h sa=%h want pc=4 sa=3", PC, state);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   errs;
        errs = 0;
        for (int i = 0; i < 65535; i++) begin
            drive_cycle(2'b11, 1'b0, 4'h0, 4'h0, 32'h40000000, 64'h0);
            e = sb.pop_front();
            total++;
            if (branch_count !== e.cnt || PC !== e.pc) begin
                bad++;
                errs++;
                if (errs < 5)
                    $display("FAIL sat_fill[%0d]: got cnt=%h pc=%h want cnt=%h pc=%h",
                             i, branch_count, PC, e.cnt, e.pc);
            end
        end
        total++;
        if (branch_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_full: got %h want ffff", branch_count);
        end
        drive_cycle(2'b11, 1'b0, 4'h0, 4'h0, 32'h17FFFFFE, 64'h0);
        e = sb.pop_front();
        total++;
        if (branch_count !== 16'hFFFF || PC !== e.pc) begin
            bad++;
            $display("FAIL sat_hold: got cnt=%h pc=%h want cnt=ffff pc=%h", branch_count, PC, e.pc);
        end
        drive_cycle(2'b10, 1'b0, 4'h0, 4'h0, 32'h0, 64'h40);
        e = sb.pop_front();
        total++;
        if (branch_count !== 16'hFFFF || PC !== 64'h40) begin
            bad++;
            $display("FAIL sat_hold_br: got cnt=%h pc=%h want cnt=ffff pc=40", branch_count, PC);
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_jumps();
        test_cb_flags();
        test_br_misalign();
        test_wrap();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
